// File: rtl/regfile_32x64_if.sv
// Register-file bus: two read ports and one write port between decode and execute.
// The datapath side uses the master modport; the register file uses the slave modport.
interface regfile_32x64_if #(
  parameter int WIDTH = 64
);
  logic [4:0]       ReadRegister1;
  logic [4:0]       ReadRegister2;
  logic [4:0]       WriteRegister;
  logic             RegWrite;
  logic [WIDTH-1:0] WriteData;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;

  modport master (
    output ReadRegister1, ReadRegister2, WriteRegister, RegWrite, WriteData,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  ReadRegister1, ReadRegister2, WriteRegister, RegWrite, WriteData,
    output ReadData1, ReadData2
  );
endinterface

// File: rtl/regfile_32x64.sv
// 32 x WIDTH architectural register file with XZR at index 31.
// It has two combinational read ports, one synchronous write port, and optional write-to-read bypass.
module regfile_32x64 #(
  parameter int WIDTH  = 64,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  regfile_32x64_if.slave  rf
);
  logic [WIDTH-1:0] r_regs [0:30];
  logic [30:0]      w_wen;
  logic [WIDTH-1:0] w_rd1;
  logic [WIDTH-1:0] w_rd2;
  logic             w_byp1;
  logic             w_byp2;

  // One-hot write decode; index 31 has no storage, so it never gets an enable.
  always_comb begin
    w_wen = '0;
    for (int k = 0; k < 31; k++) begin
      w_wen[k] = rf.RegWrite && (rf.WriteRegister == 5'(k));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 31; k++) begin
        r_regs[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 31; k++) begin
        if (w_wen[k]) r_regs[k] <= rf.WriteData;
      end
    end
  end

  // The 32:1 read selection has no matching term for index 31, so that index reads zero.
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    for (int k = 0; k < 31; k++) begin
      if (rf.ReadRegister1 == 5'(k)) w_rd1 = r_regs[k];
      if (rf.ReadRegister2 == 5'(k)) w_rd2 = r_regs[k];
    end
  end

  assign w_byp1 = (BYPASS != 0) && reset_n && rf.RegWrite &&
                  (rf.WriteRegister == rf.ReadRegister1) && (rf.ReadRegister1 != 5'd31);
  assign w_byp2 = (BYPASS != 0) && reset_n && rf.RegWrite &&
                  (rf.WriteRegister == rf.ReadRegister2) && (rf.ReadRegister2 != 5'd31);

  assign rf.ReadData1 = w_byp1 ? rf.WriteData : w_rd1;
  assign rf.ReadData2 = w_byp2 ? rf.WriteData : w_rd2;
endmodule

// File: tb/tb_regfile_32x64.sv
// Directed bench for regfile_32x64: a bypass and a non-bypass instance share one stimulus stream.
module tb_regfile_32x64;
  localparam int W = 64;

  logic clk = 1'b0;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  regfile_32x64_if #(.WIDTH(W)) ifb ();
  regfile_32x64_if #(.WIDTH(W)) ifn ();

  assign ifn.ReadRegister1 = ifb.ReadRegister1;
  assign ifn.ReadRegister2 = ifb.ReadRegister2;
  assign ifn.WriteRegister = ifb.WriteRegister;
  assign ifn.RegWrite      = ifb.RegWrite;
  assign ifn.WriteData     = ifb.WriteData;

  regfile_32x64 #(.WIDTH(W), .BYPASS(1)) u_dut_b (.clk(clk), .reset_n(reset_n), .rf(ifb));
  regfile_32x64 #(.WIDTH(W), .BYPASS(0)) u_dut_n (.clk(clk), .reset_n(reset_n), .rf(ifn));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wr, input logic [W-1:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    ifb.RegWrite      = we;
    ifb.WriteRegister = wr;
    ifb.WriteData     = wd;
    ifb.ReadRegister1 = r1;
    ifb.ReadRegister2 = r2;
  endtask

  // Checks both ports of both instances; expected values may differ between them.
  task automatic rd_chk(input string tag, input logic [4:0] idx,
                        input logic [W-1:0] exp_b, input logic [W-1:0] exp_n);
    ifb.ReadRegister1 = idx;
    ifb.ReadRegister2 = idx;
    #1;
    chk({tag, "_b1"}, ifb.ReadData1, exp_b);
    chk({tag, "_b2"}, ifb.ReadData2, exp_b);
    chk({tag, "_n1"}, ifn.ReadData1, exp_n);
    chk({tag, "_n2"}, ifn.ReadData2, exp_n);
  endtask

  task automatic write_reg(input logic [4:0] wr, input logic [W-1:0] wd);
    @(negedge clk);
    drive(1'b1, wr, wd, wr, wr);
    @(posedge clk);
    #1;
    @(negedge clk);
    ifb.RegWrite = 1'b0;
  endtask

  logic [W-1:0] v;
  logic [W-1:0] old7;

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 5'd0, '0, 5'd0, 5'd0);
    #12;
    rd_chk("rst_x0", 5'd0, '0, '0);
    rd_chk("rst_x31", 5'd31, '0, '0);
    @(negedge clk);
    reset_n = 1'b1;

    // Asynchronous clear without a clock edge.
    write_reg(5'd5, 64'hDEAD_BEEF_0000_1234);
    rd_chk("x5_wr", 5'd5, 64'hDEAD_BEEF_0000_1234, 64'hDEAD_BEEF_0000_1234);
    #1;
    reset_n = 1'b0;
    #1;
    chk("x5_async_clr", ifb.ReadData1, '0);
    chk("x5_async_clr_n", ifn.ReadData1, '0);
    @(negedge clk);
    reset_n = 1'b1;

    // Write every storage register, then read each one back.
    for (int k = 0; k < 31; k++) begin
      @(negedge clk);
      drive(1'b1, 5'(k), {32'hA5A5_0000 + 32'(k), 32'(k)}, 5'd31, 5'd31);
    end
    @(negedge clk);
    ifb.RegWrite = 1'b0;
    for (int k = 0; k < 31; k++) begin
      v = {32'hA5A5_0000 + 32'(k), 32'(k)};
      rd_chk($sformatf("all_x%0d", k), 5'(k), v, v);
    end

    // Writes to the zero register.
    @(negedge clk);
    drive(1'b1, 5'd31, '1, 5'd31, 5'd31);
    #1;
    chk("xzr_pre_b", ifb.ReadData1, '0);
    chk("xzr_pre_n", ifn.ReadData2, '0);
    @(posedge clk);
    #1;
    chk("xzr_post_b", ifb.ReadData2, '0);
    chk("xzr_post_n", ifn.ReadData1, '0);
    @(negedge clk);
    ifb.RegWrite = 1'b0;

    // Same-cycle bypass versus no bypass.
    old7 = {32'hA5A5_0007, 32'h7};
    @(negedge clk);
    drive(1'b1, 5'd7, 64'h1111_2222_3333_4444, 5'd7, 5'd7);
    #1;
    chk("byp_b1", ifb.ReadData1, 64'h1111_2222_3333_4444);
    chk("byp_b2", ifb.ReadData2, 64'h1111_2222_3333_4444);
    chk("nobyp_n1", ifn.ReadData1, old7);
    chk("nobyp_n2", ifn.ReadData2, old7);
    drive(1'b1, 5'd7, 64'h1111_2222_3333_4444, 5'd7, 5'd6);
    #1;
    chk("byp_port2_other", ifb.ReadData2, {32'hA5A5_0006, 32'h6});
    @(negedge clk);
    ifb.RegWrite = 1'b0;
    rd_chk("x7_commit", 5'd7, 64'h1111_2222_3333_4444, 64'h1111_2222_3333_4444);

    // Back-to-back writes: each value is visible for exactly one cycle.
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      drive(1'b1, 5'd4, 64'(i), 5'd4, 5'd4);
      @(posedge clk);
      #1;
      chk($sformatf("b2b_%0d", i), ifn.ReadData1, 64'(i));
    end
    @(negedge clk);
    ifb.RegWrite = 1'b0;
    rd_chk("b2b_last", 5'd4, 64'd3, 64'd3);

    // Enable gating after a fresh reset.
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    @(negedge clk);
    drive(1'b0, 5'd3, '1, 5'd3, 5'd3);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rd_chk("gate_x3", 5'd3, '0, '0);
    rd_chk("gate_x7_clr", 5'd7, '0, '0);

    // Reset collides with a write; the clear wins and bypass is suppressed.
    @(negedge clk);
    drive(1'b1, 5'd9, 64'h55, 5'd9, 5'd9);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_byp_sup", ifb.ReadData1, '0);
    @(posedge clk);
    #1;
    chk("rst_wr_ignored", ifn.ReadData1, '0);
    @(negedge clk);
    ifb.RegWrite = 1'b0;
    reset_n = 1'b1;
    rd_chk("coll_x9", 5'd9, '0, '0);
    write_reg(5'd9, 64'h66);
    rd_chk("coll_x9_66", 5'd9, 64'h66, 64'h66);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
